alu_serial_ctrl: RTL and testbench

Bit-serial sequencer that drives the team's 1-bit ALU slice (alu_1_bit) to execute a WIDTH-bit operation, one bit per clock, LSB first. It accepts a start request with two WIDTH-bit operands and a 3-bit opcode, feeds operand bits and the chained carry/borrow to the slice, and collects the result bits it returns. When all bits are done it presents the WIDTH-bit result with carry, zero and parity flags.

---
 rtl/alu_serial_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_alu_serial_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// alu_serial_ctrl
//
// Bit-serial sequencer for the 1-bit ALU slice (alu_1_bit). A WIDTH-bit
// operation is executed one bit per clock, LSB first. Operand bits and the
// chained carry/borrow are presented to the slice combinationally from
// registers. The returned result bit is shifted into a result register, and
// the slice's carry-out is fed back into the next bit. Once every bit has
// been processed, the result and its flags are registered and a done pulse
// is raised.
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   start     in   operation request, sampled only while idle
//   a, b      in   WIDTH-bit operands, captured on an accepted start
//   op        in   3-bit opcode [0:2], captured on an accepted start
//   alu_a     out  current operand A bit to the slice
//   alu_b     out  current operand B bit to the slice
//   alu_cin   out  carry/borrow-in to the slice
//   alu_op    out  opcode to the slice (000 while not running)
//   alu_o     in   result bit from the slice
//   alu_cout  in   carry/borrow-out from the slice
//   busy      out  high while bits are being processed
//   done      out  one-cycle pulse in the cycle before result/flags update
//   result    out  final WIDTH-bit result, held until the next operation ends
//   carry     out  final carry (add) or borrow (sub); 0 for logic ops
//   zero      out  1 when result == 0 (meaningful after the first done)
//   parity    out  XOR of all result bits
// ---------------------------------------------------------------------------
module alu_serial_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [0:2]       op,
    output logic             alu_a,
    output logic             alu_b,
    output logic             alu_cin,
    output logic [0:2]       alu_op,
    input  logic             alu_o,
    input  logic             alu_cout,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry,
    output logic             zero,
    output logic             parity
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] S_IDLE = 2'b00;
    localparam logic [1:0] S_RUN  = 2'b01;
    localparam logic [1:0] S_DONE = 2'b10;

    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    localparam logic [0:2] OP_NONE = 3'b000;
    localparam logic [0:2] OP_ADD  = 3'b001;
    localparam logic [0:2] OP_SUB  = 3'b010;

    // -----------------------------------------------------------------------
    // State and datapath registers
    // -----------------------------------------------------------------------
    logic [1:0]       state_q,  state_d;
    logic [WIDTH-1:0] a_sh_q,   a_sh_d;
    logic [WIDTH-1:0] b_sh_q,   b_sh_d;
    logic [WIDTH-1:0] res_sh_q, res_sh_d;
    logic [0:2]       op_q,     op_d;
    logic             cy_q,     cy_d;
    logic [CW-1:0]    cnt_q,    cnt_d;

    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q,  carry_d;
    logic             zero_q,   zero_d;
    logic             parity_q, parity_d;

    logic running;
    logic is_arith;

    assign running  = (state_q == S_RUN);
    // Only add and subtract produce a meaningful carry/borrow. Forcing it to
    // zero here keeps the flag clean even if a slice reports stray cout.
    assign is_arith = (op_q == OP_ADD) || (op_q == OP_SUB);

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        res_sh_d = res_sh_q;
        op_d     = op_q;
        cy_d     = cy_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        carry_d  = carry_q;
        zero_d   = zero_q;
        parity_d = parity_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_sh_d   = a;
                    b_sh_d   = b;
                    op_d     = op;
                    cy_d     = 1'b0;
                    cnt_d    = '0;
                    res_sh_d = '0;
                    state_d  = S_RUN;
                end
            end

            S_RUN: begin
                // Operands shift right so bit 0 always holds the bit
                // being processed. Result bits enter at the MSB, so after
                // WIDTH shifts the first (LSB) result bit ends up at bit 0.
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                res_sh_d = {alu_o, res_sh_q[WIDTH-1:1]};
                cy_d     = alu_cout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    state_d = S_DONE;
                end
            end

            S_DONE: begin
                result_d = res_sh_q;
                carry_d  = is_arith & cy_q;
                zero_d   = ~|res_sh_q;
                parity_d = ^res_sh_q;
                state_d  = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_sh_q <= '0;
            op_q     <= OP_NONE;
            cy_q     <= 1'b0;
            cnt_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
            parity_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_sh_q <= res_sh_d;
            op_q     <= op_d;
            cy_q     <= cy_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
            parity_q <= parity_d;
        end
    end

    // -----------------------------------------------------------------------
    // Slice interface: gated so the slice sees a quiet 000 opcode and zero
    // operands whenever no operation is in progress.
    // -----------------------------------------------------------------------
    assign alu_a   = running & a_sh_q[0];
    assign alu_b   = running & b_sh_q[0];
    assign alu_cin = running & cy_q;
    assign alu_op  = running ? op_q : OP_NONE;

    assign busy    = running;
    assign done    = (state_q == S_DONE);
    assign result  = result_q;
    assign carry   = carry_q;
    assign zero    = zero_q;
    assign parity  = parity_q;

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// ---------------------------------------------------------------------------
// tb_alu_serial_ctrl
//
// Directed testbench for alu_serial_ctrl with WIDTH=8. A behavioural 1-bit
// ALU slice is closed around the controller. Expected results are
// hand-computed constants. Expected per-bit carry/borrow-in values come from
// whole-word arithmetic on the low operand bits.
// ---------------------------------------------------------------------------
module tb_alu_serial_ctrl;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [0:2]   op;
    logic         alu_a;
    logic         alu_b;
    logic         alu_cin;
    logic [0:2]   alu_op;
    logic         alu_o;
    logic         alu_cout;
    logic         busy;
    logic         done;
    logic [W-1:0] result;
    logic         carry;
    logic         zero;
    logic         parity;

    int checks;
    int failures;
    logic [W-1:0] prev_res;

    alu_serial_ctrl #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .a        (a),
        .b        (b),
        .op       (op),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_cin  (alu_cin),
        .alu_op   (alu_op),
        .alu_o    (alu_o),
        .alu_cout (alu_cout),
        .busy     (busy),
        .done     (done),
        .result   (result),
        .carry    (carry),
        .zero     (zero),
        .parity   (parity)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural 1-bit ALU slice.
    always_comb begin
        alu_o    = 1'b0;
        alu_cout = 1'b0;
        case (alu_op)
            3'b001: begin
                alu_o    = alu_a ^ alu_b ^ alu_cin;
                alu_cout = (alu_a & alu_b) | (alu_cin & (alu_a ^ alu_b));
            end
            3'b010: begin
                alu_o    = alu_a ^ alu_b ^ alu_cin;
                alu_cout = (~alu_a & alu_b) | (~(alu_a ^ alu_b) & alu_cin);
            end
            3'b100: alu_o = alu_a | alu_b;
            3'b101: alu_o = alu_a & alu_b;
            3'b110: alu_o = ~alu_a;
            default: begin
                alu_o    = 1'b0;
                alu_cout = 1'b0;
            end
        endcase
    end

    // Carry/borrow into bit i, from whole-word arithmetic on bits [i-1:0].
    function automatic logic exp_cin(logic [W-1:0] xa, logic [W-1:0] xb,
                                     logic [2:0] xop, int i);
        logic [W:0] m;
        logic [W:0] s;
        m = (({{W{1'b0}}, 1'b1}) << i) - 1'b1;
        if (xop == 3'b001) begin
            s = ({1'b0, xa} & m) + ({1'b0, xb} & m);
            return s[i];
        end else if (xop == 3'b010) begin
            return (({1'b0, xa} & m) < ({1'b0, xb} & m));
        end
        return 1'b0;
    endfunction

    // Runs one operation from IDLE and checks every cycle of it.
    task automatic run_op(input logic [W-1:0] xa, input logic [W-1:0] xb,
                          input logic [2:0] xop, input logic [W-1:0] er,
                          input logic ec, input logic ez, input logic ep);
        logic [2:0] exp_bits;
        start = 1'b1;
        a = xa;
        b = xb;
        op = xop;
        @(posedge clk); #1;
        start = 1'b0;
        // Operands may change freely after acceptance.
        a = ~xa;
        b = ~xb;
        op = 3'b111;
        for (int i = 0; i < W; i++) begin
            exp_bits = {xa[i], xb[i], exp_cin(xa, xb, xop, i)};
            checks++;
            if ({alu_a, alu_b, alu_cin} !== exp_bits) begin
                failures++;
                $display("FAIL slice_in bit%0d: got %b expected %b", i,
                         {alu_a, alu_b, alu_cin}, exp_bits);
            end
            checks++;
            if ({busy, done, alu_op} !== {1'b1, 1'b0, xop}) begin
                failures++;
                $display("FAIL run_ctl bit%0d: got busy/done/op=%b expected %b", i,
                         {busy, done, alu_op}, {1'b1, 1'b0, xop});
            end
            checks++;
            if (result !== prev_res) begin
                failures++;
                $display("FAIL result_hold bit%0d: got %h expected %h", i, result, prev_res);
            end
            @(posedge clk); #1;
        end
        checks++;
        if ({busy, done, alu_op} !== 5'b01000) begin
            failures++;
            $display("FAIL done_state: got busy/done/op=%b expected 01000",
                     {busy, done, alu_op});
        end
        @(posedge clk); #1;
        checks++;
        if ({done, result, carry, zero, parity} !== {1'b0, er, ec, ez, ep}) begin
            failures++;
            $display("FAIL result op=%b a=%h b=%h: got res=%h c=%b z=%b p=%b expected res=%h c=%b z=%b p=%b done=%b",
                     xop, xa, xb, result, carry, zero, parity, er, ec, ez, ep, done);
        end
        prev_res = er;
        $display("op=%b a=%h b=%h -> result=%h carry=%b zero=%b parity=%b",
                 xop, xa, xb, result, carry, zero, parity);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b1;
        a = 8'hFF;
        b = 8'hFF;
        op = 3'b001;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({busy, done, result, carry, zero, parity, alu_a, alu_b, alu_cin, alu_op} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got busy=%b done=%b res=%h c=%b z=%b p=%b a=%b b=%b cin=%b op=%b expected all 0",
                     busy, done, result, carry, zero, parity, alu_a, alu_b, alu_cin, alu_op);
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, result, zero, alu_op} !== '0) begin
            failures++;
            $display("FAIL idle_after_reset: got busy=%b done=%b res=%h z=%b op=%b expected 0",
                     busy, done, result, zero, alu_op);
        end
        prev_res = '0;
        $display("reset: busy=%b done=%b result=%h zero=%b", busy, done, result, zero);
    endtask

    task automatic test_ops();
        run_op(8'h5A, 8'hC3, 3'b001, 8'h1D, 1'b1, 1'b0, 1'b0);
        run_op(8'h10, 8'h20, 3'b010, 8'hF0, 1'b1, 1'b0, 1'b0);
        run_op(8'h20, 8'h20, 3'b010, 8'h00, 1'b0, 1'b1, 1'b0);
        run_op(8'hF0, 8'h0F, 3'b101, 8'h00, 1'b0, 1'b1, 1'b0);
        run_op(8'h55, 8'h0F, 3'b110, 8'hAA, 1'b0, 1'b0, 1'b0);
        run_op(8'h01, 8'h02, 3'b100, 8'h03, 1'b0, 1'b0, 1'b0);
        run_op(8'hFF, 8'hFF, 3'b011, 8'h00, 1'b0, 1'b1, 1'b0);
        run_op(8'hFF, 8'h01, 3'b001, 8'h00, 1'b1, 1'b1, 1'b0);
        run_op(8'h01, 8'h00, 3'b001, 8'h01, 1'b0, 1'b0, 1'b1);
        run_op(8'h00, 8'h01, 3'b010, 8'hFF, 1'b1, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        start = 1'b1;
        a = 8'h33;
        b = 8'h11;
        op = 3'b001;
        @(posedge clk); #1;
        for (int i = 0; i < W; i++) begin
            // start remains high and the operands keep changing during RUN.
            a = 8'($urandom);
            b = 8'($urandom);
            checks++;
            if (busy !== 1'b1) begin
                failures++;
                $display("FAIL b2b_busy1 bit%0d: got %b expected 1", i, busy);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done1: got %b expected 1", done);
        end
        a = 8'h80;
        b = 8'h80;
        @(posedge clk); #1;
        checks++;
        if ({busy, done, result, carry} !== {1'b0, 1'b0, 8'h44, 1'b0}) begin
            failures++;
            $display("FAIL b2b_first: got busy=%b done=%b res=%h c=%b expected busy=0 done=0 res=44 c=0",
                     busy, done, result, carry);
        end
        $display("b2b op1 a=33 b=11 -> result=%h carry=%b", result, carry);
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL b2b_restart: got busy=%b expected 1", busy);
        end
        start = 1'b0;
        repeat (W) @(posedge clk);
        #1;
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL b2b_done2: got %b expected 1", done);
        end
        @(posedge clk); #1;
        checks++;
        if ({result, carry, zero, parity} !== {8'h00, 1'b1, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL b2b_second: got res=%h c=%b z=%b p=%b expected res=00 c=1 z=1 p=0",
                     result, carry, zero, parity);
        end
        prev_res = 8'h00;
        $display("b2b op2 a=80 b=80 -> result=%h carry=%b zero=%b", result, carry, zero);
    endtask

    task automatic test_reset_mid_run();
        logic seen_done;
        start = 1'b1;
        a = 8'h5A;
        b = 8'hC3;
        op = 3'b001;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, result, zero, alu_op, alu_a, alu_b, alu_cin} !== '0) begin
            failures++;
            $display("FAIL reset_mid_run: got busy=%b done=%b res=%h z=%b op=%b a=%b b=%b cin=%b expected all 0",
                     busy, done, result, zero, alu_op, alu_a, alu_b, alu_cin);
        end
        @(negedge clk);
        rst_n = 1'b1;
        seen_done = 1'b0;
        for (int i = 0; i < W + 3; i++) begin
            @(posedge clk); #1;
            if (done || busy) seen_done = 1'b1;
        end
        checks++;
        if (seen_done !== 1'b0) begin
            failures++;
            $display("FAIL abort_no_done: got activity=%b expected 0", seen_done);
        end
        $display("reset mid-run: busy=%b done=%b result=%h", busy, done, result);
        prev_res = '0;
        run_op(8'h0F, 8'h01, 3'b001, 8'h10, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        prev_res = '0;
        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        op = 3'b000;
        #1;
        test_reset();
        test_ops();
        test_back_to_back();
        test_reset_mid_run();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
